// File: rtl/fizzbuzz_stream_gen_if.sv
// Output stream of the divisibility-flag generator.
// The master drives beats and the slave returns out_ready.
interface fizzbuzz_stream_gen_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
) ();
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic [NUM_CH-1:0] out_hit;
    logic              out_all;
    logic              out_none;

    modport master (
        output out_valid,
        input  out_ready,
        output out_count,
        output out_hit,
        output out_all,
        output out_none
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_count,
        input  out_hit,
        input  out_all,
        input  out_none
    );
endinterface

// File: rtl/fizzbuzz_stream_gen.sv
// Counts 0..max_count and flags, per channel, counts divisible by a
// runtime divisor using incremental residues.
module fizzbuzz_stream_gen #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CNT_W-1:0]        max_count,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    output logic                    busy,
    output logic                    done,
    fizzbuzz_stream_gen_if.master   out
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [DIV_W-1:0] div_q [NUM_CH];
    logic [DIV_W-1:0] div_d [NUM_CH];
    logic [DIV_W-1:0] res_q [NUM_CH];
    logic [DIV_W-1:0] res_d [NUM_CH];
    logic             done_q, done_d;
    logic             valid;
    logic             xfer;
    logic             last;
    logic [NUM_CH-1:0] hit;

    assign valid = (state_q == RUN);
    assign xfer  = valid && out.out_ready;
    assign last  = (cnt_q == max_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        done_d  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i] = div_q[i];
            res_d[i] = res_q[i];
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    max_d   = max_count;
                    cnt_d   = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        div_d[i] = div_i[i*DIV_W +: DIV_W];
                        res_d[i] = '0;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        // Wrap at div-1; div=0 wraps harmlessly and never hits
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (res_q[i] == div_q[i] - 1'b1)
                                res_d[i] = '0;
                            else
                                res_d[i] = res_q[i] + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            max_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = valid && (res_q[i] == '0) && (div_q[i] != '0);
        end
    end

    assign out.out_valid = valid;
    assign out.out_count = cnt_q;
    assign out.out_hit   = hit;
    assign out.out_all   = valid && (&hit);
    assign out.out_none  = valid && !(|hit);
    assign busy          = valid;
    assign done          = done_q;

endmodule

// File: tb/tb_fizzbuzz_stream_gen.sv
// Scoreboard bench for fizzbuzz_stream_gen: driver pushes expected beats,
// a monitor pops and compares on every accepted beat.
module tb_fizzbuzz_stream_gen;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [CNT_W-1:0]  cnt;
        logic [NUM_CH-1:0] hit;
        bit                last;
    } beat_t;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic [CNT_W-1:0]        max_count;
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic                    busy;
    logic                    done;

    fizzbuzz_stream_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) sif ();

    fizzbuzz_stream_gen #(
        .NUM_CH(NUM_CH),
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .max_count(max_count),
        .div_i    (div_i),
        .busy     (busy),
        .done     (done),
        .out      (sif.master)
    );

    int    checks   = 0;
    int    failures = 0;
    beat_t expq[$];
    int    rmode    = 0;
    bit    exp_done = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // ready: always 1, or repeating 1,0,0,1
    initial begin
        int ph = 0;
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0) begin
                sif.out_ready = 1'b1;
            end else begin
                ph = (ph + 1) % 4;
                sif.out_ready = (ph == 0 || ph == 3);
            end
        end
    end

    // monitor
    initial begin
        bit               stalled = 0;
        logic [CNT_W-1:0] s_cnt;
        logic [1:0]       s_hit;
        beat_t            e;
        forever begin
            @(negedge clk);
            chk("done", done, exp_done);
            exp_done = 0;
            chk("busy_eq_valid", busy, sif.out_valid);
            if (reset) begin
                stalled = 0;
                continue;
            end
            if (!sif.out_valid) begin
                chk("idle_flags", {sif.out_hit, sif.out_all, sif.out_none}, 0);
            end
            if (stalled) begin
                chk("stall_valid", sif.out_valid, 1);
                chk("stall_data", {sif.out_count, sif.out_hit}, {s_cnt, s_hit});
            end
            if (sif.out_valid && sif.out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got count %0d expected none",
                             sif.out_count);
                end else begin
                    e = expq.pop_front();
                    chk("count", sif.out_count, e.cnt);
                    chk("hit", sif.out_hit, e.hit);
                    chk("all", sif.out_all, &e.hit);
                    chk("none", sif.out_none, ~|e.hit);
                    if (e.last) exp_done = 1;
                end
            end
            stalled = sif.out_valid && !sif.out_ready;
            s_cnt   = sif.out_count;
            s_hit   = sif.out_hit;
        end
    end

    function automatic logic [1:0] model_hit(int c, int d0, int d1);
        logic [1:0] h;
        h[0] = (d0 != 0) && (c % d0 == 0);
        h[1] = (d1 != 0) && (c % d1 == 0);
        return h;
    endfunction

    task automatic push_model(int m, int d0, int d1);
        beat_t b;
        for (int c = 0; c <= m; c++) begin
            b.cnt  = CNT_W'(c);
            b.hit  = model_hit(c, d0, d1);
            b.last = (c == m);
            expq.push_back(b);
        end
    endtask

    task automatic push_mask(int m, logic [15:0] h0, logic [15:0] h1);
        beat_t b;
        for (int c = 0; c <= m; c++) begin
            b.cnt  = CNT_W'(c);
            b.hit  = {h1[c], h0[c]};
            b.last = (c == m);
            expq.push_back(b);
        end
    endtask

    task automatic launch(int m, int d0, int d1);
        start     = 1'b1;
        max_count = CNT_W'(m);
        div_i     = {DIV_W'(d1), DIV_W'(d0)};
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("first_valid", sif.out_valid, 1);
        chk("first_count", sif.out_count, 0);
        chk("first_busy", busy, 1);
    endtask

    task automatic wait_done(int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got none expected done within %0d", budget);
        end
    endtask

    initial begin
        logic [15:0] h0;
        logic [15:0] h1;
        bit          hit7;
        reset     = 1'b1;
        start     = 1'b0;
        max_count = '0;
        div_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_count", sif.out_count, 0);
        chk("rst_hit", sif.out_hit, 0);
        chk("rst_all", sif.out_all, 0);
        chk("rst_none", sif.out_none, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // div0=3, div1=5, max=15, hand masks
        h0 = 16'b1001_0010_0100_1001;
        h1 = 16'b1000_0100_0010_0001;
        push_mask(15, h0, h1);
        launch(15, 3, 5);
        wait_done(100);
        @(posedge clk);
        #1;

        // same run with ready toggling
        rmode = 1;
        push_mask(15, h0, h1);
        launch(15, 3, 5);
        wait_done(200);
        rmode = 0;
        @(posedge clk);
        #1;

        // div0=0 never hits, div1=1 always hits
        push_mask(3, 16'h0000, 16'h000f);
        launch(3, 0, 1);
        wait_done(50);
        @(posedge clk);
        #1;

        // single-beat run, then back-to-back start on the done cycle
        push_mask(0, 16'h0001, 16'h0001);
        launch(0, 4, 2);
        wait_done(20);
        push_mask(0, 16'h0001, 16'h0001);
        launch(0, 4, 2);
        wait_done(20);
        @(posedge clk);
        #1;

        // reset mid-run at count 7
        push_model(15, 3, 5);
        launch(15, 3, 5);
        hit7 = 0;
        for (int i = 0; i < 30; i++) begin
            if (sif.out_valid && sif.out_count == 7) begin
                hit7 = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("reached_7", hit7, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expq.delete();
        chk("abort_valid", sif.out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        push_model(4, 2, 3);
        launch(4, 2, 3);
        wait_done(50);
        @(posedge clk);
        #1;

        // start and new divisors during RUN are ignored
        push_model(10, 3, 5);
        launch(10, 3, 5);
        repeat (3) @(posedge clk);
        #1;
        start     = 1'b1;
        div_i     = {8'd7, 8'd7};
        max_count = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(50);
        @(posedge clk);
        #1;

        // divisor larger than max hits only at count 0
        push_mask(8, 16'h0111, 16'h0001);
        launch(8, 4, 20);
        wait_done(50);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
        chk("queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fizzbuzz_stream_gen.md
Name: fizzbuzz_stream_gen

Overview:
Parametrised, multi-channel divisibility-flag generator. It counts 0..max_count and flags, per channel, every count divisible by that channel's runtime divisor. Output is a valid/ready stream with backpressure; each run is launched by a start pulse and ends with a done pulse. It feeds downstream pattern checkers and scoreboard logic in the puzzle/exercise datapath.

Parameters:
NUM_CH, 2, number of independent divisor channels (>=1)
DIV_W, 8, width of each divisor and residue counter
CNT_W, 16, width of the sequence counter and max_count

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch a run; sampled only in IDLE
max_count  input  CNT_W  last count value of the run; latched on start
div_i  input  NUM_CH*DIV_W  channel i divisor at bits [i*DIV_W +: DIV_W]; latched on start
out_ready  input  1  downstream accepts beat
out_valid  output  1  beat present
out_count  output  CNT_W  current sequence value
out_hit  output  NUM_CH  bit i = out_count divisible by divisor i
out_all  output  1  AND of out_hit
out_none  output  1  NOR of out_hit
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse after the final beat transfers

Behaviour:
- Reset: state IDLE; out_valid, out_count, out_hit, out_all, busy and done = 0; out_none = 0 (forced while out_valid=0); latched divisors and max = 0. Reset in mid-run aborts immediately, with no done pulse.
- FSM states: IDLE, RUN.
- IDLE, start=1: latch max_count and div_i; count <= 0; all residues <= 0; go to RUN.
- IDLE, start=0: hold. start is ignored while in RUN.
- First beat latency: out_valid=1 in the cycle after start is sampled, with out_count=0.
- RUN: out_valid=1. A transfer occurs when out_valid && out_ready.
- No transfer: out_count, out_hit, out_all and out_none hold stable.
- Transfer with count != max: count += 1. Each residue[i] <= (residue[i] == div[i]-1) ? 0 : residue[i]+1.
- Transfer with count == max: go to IDLE; out_valid <= 0; done <= 1 for exactly one cycle.
- A start sampled in the same cycle that done is high is accepted (back-to-back runs, one idle cycle between runs).
- out_hit[i] = (residue[i] == 0) && (div[i] != 0). div[i]=0 means the channel never hits. div[i]=1 means the channel hits on every beat.
- Residues are maintained incrementally; no divider or modulo hardware.
- out_all = &out_hit. out_none = ~|out_hit. Both are qualified by out_valid (0 when out_valid=0).
- max_count=0: exactly one beat (count 0, all nonzero-divisor channels hit), then done.
- max_count = 2^CNT_W-1: the full range runs, and the counter never wraps within a run.
- Divisor > max_count: that channel hits only at count 0.
- Outputs are registered or derived from registered state only; no combinational path from out_ready to out_valid or data.
- Changing div_i or max_count during RUN has no effect on the active run.

Test Plan:
- NUM_CH=2, div={5,3}, max=15, out_ready=1 -> 16 consecutive beats, count 0..15. hit[0] at 0,3,6,9,12,15; hit[1] at 0,5,10,15; out_all at 0 and 15. done pulses the cycle after count=15.
- Same run, out_ready toggling 1,0,0,1 repeatedly -> no beat lost or duplicated, data stable while stalled, done still follows count=15.
- div={0,1}, max=3 -> hit[0] always 0, hit[1] always 1, out_none never asserted, out_all never asserted.
- max=0, div={4,2} -> a single beat with count=0, hit=2'b11, out_all=1, then done. A second start on the done cycle -> a new beat with count=0 on the next cycle.
- Reset asserted while count=7 -> next cycle out_valid=0 and busy=0, no done pulse; a new start restarts at count=0 with residues 0.
- start pulsed during RUN, and div_i changed mid-run -> ignored; the sequence continues with the originally latched divisors.
